// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, with a saturating
// shift counter and a one-cycle pulse marking the completion of a full frame of shifts.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CntW-1:0]  shift_cnt,
  output logic             frame_done,
  output logic             drained
);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShr  = 2'b01,
    ModeShl  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        ModeShr: begin
          q_d   = {sin_msb, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        ModeShl: begin
          q_d   = {q_q[WIDTH-2:0], sin_lsb};
          shift = 1'b1;
        end
        ModeLoad: begin
          q_d   = pin;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Count saturates at WIDTH; the pulse fires only on the transition into saturation.
    if (shift && (cnt_q != CntFull)) begin
      cnt_d  = cnt_q + CntW'(1);
      done_d = (cnt_q == CntLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = q_q;
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;
  assign sout_msb   = q_q[WIDTH-1];
  assign sout_lsb   = q_q[0];
  assign drained    = (cnt_q == CntFull);

endmodule
